// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and byte masks.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        ACCESS2 = 2'b10,
        RESP    = 2'b11
    } lsu_state_e;

    // Right-aligned run of ones, one bit per byte touched by the access.
    function automatic logic [7:0] byte_mask(input lsu_size_e size);
        case (size)
            SZ_BYTE: return 8'h01;
            SZ_HALF: return 8'h03;
            SZ_WORD: return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: store byte enables/data shifting, two-beat read merge, load extension.
// Latency: purely combinational.
// Backpressure: none; the parent holds all inputs stable.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  lsu_size_e                           size,
    input  logic                                is_unsigned,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]     offset,
    input  logic [DATA_WIDTH-1:0]               wdata,
    output logic [DATA_WIDTH/8-1:0]             be_lo,
    output logic [DATA_WIDTH/8-1:0]             be_hi,
    output logic [DATA_WIDTH-1:0]               wdata_lo,
    output logic [DATA_WIDTH-1:0]               wdata_hi,
    input  logic [DATA_WIDTH-1:0]               rdata_lo,
    input  logic [DATA_WIDTH-1:0]               rdata_hi,
    output logic [DATA_WIDTH-1:0]               rdata_ext
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int NB2 = 2 * NB;
    localparam int OW  = $clog2(NB);

    logic [OW+2:0]             bit_off;
    logic [NB2-1:0]            mask_full;
    logic [2*DATA_WIDTH-1:0]   wdata_full;
    logic [DATA_WIDTH-1:0]     raw;
    int                        nbits;
    logic                      sign_bit;

    assign bit_off    = {offset, 3'b000};
    assign mask_full  = NB2'(byte_mask(size)) << offset;
    assign wdata_full = {{DATA_WIDTH{1'b0}}, wdata} << bit_off;

    // Upper half of each pair belongs to the second beat when the access spills.
    assign be_lo    = mask_full[NB-1:0];
    assign be_hi    = mask_full[NB2-1:NB];
    assign wdata_lo = wdata_full[DATA_WIDTH-1:0];
    assign wdata_hi = wdata_full[2*DATA_WIDTH-1:DATA_WIDTH];

    assign raw = DATA_WIDTH'({rdata_hi, rdata_lo} >> bit_off);

    always_comb begin
        nbits    = 8 << int'(size);
        sign_bit = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i == nbits - 1) sign_bit = raw[i];
        end
        if (is_unsigned) sign_bit = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            rdata_ext[i] = (i < nbits) ? raw[i] : sign_bit;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one core access at a time, split into one or two aligned bus beats.
// Latency: response two cycles after the accept cycle with no wait states, +1 per wait state, +1 beat when split.
// Backpressure: req_ready_o only in IDLE; bus beats held stable until data_ready_i.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [1:0]              req_size_i,
    input  logic                    req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    resp_valid_o,
    output logic [DATA_WIDTH-1:0]   resp_rdata_o,
    output logic                    resp_fault_o,
    output logic                    data_req_o,
    input  logic                    data_ready_i,
    output logic                    data_write_o,
    output logic [ADDR_WIDTH-1:0]   data_addr_o,
    output logic [DATA_WIDTH/8-1:0] data_be_o,
    output logic [DATA_WIDTH-1:0]   data_wdata_o,
    input  logic [DATA_WIDTH-1:0]   data_rdata_i
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int OW = $clog2(NB);

    lsu_state_e              state_q, state_d;
    logic                    write_q, uns_q, fault_q;
    lsu_size_e               size_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q, hold_q, last_q;

    logic [OW-1:0]           req_offset;
    logic                    req_misaligned, req_fault, accept, spill;
    logic [ADDR_WIDTH-1:0]   aligned_addr;
    logic [NB-1:0]           be_lo, be_hi;
    logic [DATA_WIDTH-1:0]   wdata_lo, wdata_hi, rdata_ext;

    assign req_offset     = req_addr_i[OW-1:0];
    assign req_misaligned = |(req_offset & OW'(byte_mask(lsu_size_e'(req_size_i)) >> 1));
    assign req_fault      = ((req_size_i == SZ_DWORD) && (DATA_WIDTH == 32)) ||
                            (!SPLIT_MISALIGNED && req_misaligned);
    assign accept         = req_valid_i && (state_q == IDLE);
    assign spill          = |be_hi;
    assign aligned_addr   = {addr_q[ADDR_WIDTH-1:OW], {OW{1'b0}}};

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .offset      (addr_q[OW-1:0]),
        .wdata       (wdata_q),
        .be_lo       (be_lo),
        .be_hi       (be_hi),
        .wdata_lo    (wdata_lo),
        .wdata_hi    (wdata_hi),
        .rdata_lo    (hold_q),
        .rdata_hi    (last_q),
        .rdata_ext   (rdata_ext)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            fault_q <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q <= req_write_i;
                uns_q   <= req_unsigned_i;
                fault_q <= req_fault;
                size_q  <= lsu_size_e'(req_size_i);
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
            if ((state_q == ACCESS) && !fault_q && data_ready_i) hold_q <= data_rdata_i;
            if ((state_q == ACCESS2) && data_ready_i) last_q <= data_rdata_i;
        end
    end

    // Faults spend one ACCESS cycle with the bus request masked, so a faulting
    // access responds with the same timing as a zero-wait single-beat access.
    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        data_req_o   = 1'b0;
        data_write_o = 1'b0;
        data_addr_o  = aligned_addr;
        data_be_o    = '0;
        data_wdata_o = '0;
        resp_valid_o = 1'b0;
        resp_fault_o = 1'b0;
        resp_rdata_o = '0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = ACCESS;
            end
            ACCESS: begin
                if (fault_q) begin
                    state_d = RESP;
                end else begin
                    data_req_o   = 1'b1;
                    data_write_o = write_q;
                    data_be_o    = be_lo;
                    data_wdata_o = wdata_lo;
                    if (data_ready_i) state_d = spill ? ACCESS2 : RESP;
                end
            end
            ACCESS2: begin
                data_req_o   = 1'b1;
                data_write_o = write_q;
                data_addr_o  = aligned_addr + ADDR_WIDTH'(NB);
                data_be_o    = be_hi;
                data_wdata_o = wdata_hi;
                if (data_ready_i) state_d = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                resp_fault_o = fault_q;
                if (!write_q && !fault_q) resp_rdata_o = rdata_ext;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
